// File: rtl/piece_controller.sv
// rtl/piece_controller.sv - falling-tetromino sequencer: spawn, move, gravity, hard drop, lock strobe.
// Define PIECE_CTRL_LFSR_EN to take piece types from an LFSR; otherwise types cycle 0..6.
module piece_controller #(
  parameter int SPAWN_ROW = 17,
  parameter int SPAWN_COL = 4,
  parameter int LOCK_HOLD = 4
) (
  input  logic         refreshClock,
  input  logic         reset,
  input  logic         tick,
  input  logic         btnLeft,
  input  logic         btnRight,
  input  logic         btnRotate,
  input  logic         btnDrop,
  input  logic [199:0] boardIn,
  output logic         setSignal,
  output logic [15:0]  setSpace,
  output logic [4:0]   setRow,
  output logic [3:0]   setCol,
  output logic [15:0]  pieceSpace,
  output logic [4:0]   pieceRow,
  output logic [3:0]   pieceCol,
  output logic [2:0]   blockType,
  output logic         gameOver
);

  localparam int CW = $clog2(LOCK_HOLD + 2);

  typedef enum logic [2:0] {SETTLE, SPAWN, ACTIVE, DROP, LOCK, OVER} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    row, row_n;
  logic [3:0]    col, col_n;
  logic [1:0]    rot, rot_n;
  logic [2:0]    btype, btype_n;
  logic          tick_pend, tick_pend_n;
  logic [2:0]    spawn_type;
  logic [15:0]   cur_mask, rot_mask, spawn_mask;
  logic          fits_rot, fits_left, fits_right, fits_down, fits_spawn;

  function automatic logic [15:0] base_mask(input logic [2:0] t);
    logic [15:0] m;
    case (t)
      3'd1:    m = 16'h0F00;
      3'd2:    m = 16'h0630;
      3'd3:    m = 16'h0360;
      3'd4:    m = 16'h0710;
      3'd5:    m = 16'h0740;
      3'd6:    m = 16'h0720;
      default: m = 16'h0660;
    endcase
    return m;
  endfunction

  // Row index grows upward, so clockwise maps new[i][j] = old[j][N-1-i].
  function automatic logic [15:0] rot_cw3(input logic [15:0] m);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        o[i*4+j] = m[j*4+2-i];
    return o;
  endfunction

  function automatic logic [15:0] rot_cw4(input logic [15:0] m);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[i*4+j] = m[j*4+3-i];
    return o;
  endfunction

  function automatic logic [15:0] piece_mask(input logic [2:0] t, input logic [1:0] r);
    logic [15:0] m;
    m = base_mask(t);
    for (int k = 0; k < 3; k++)
      if (k < int'(r)) begin
        if (t == 3'd1)      m = rot_cw4(m);
        else if (t != 3'd0) m = rot_cw3(m);
      end
    return m;
  endfunction

  function automatic logic fits(input logic [15:0] m, input logic [4:0] prow,
                                input logic [3:0] pcol, input logic [199:0] board);
    logic              ok;
    logic signed [6:0] r, c;
    logic [7:0]        idx;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        r   = $signed({2'b00, prow}) + 7'(i) - 7'sd2;
        c   = $signed({3'b000, pcol}) + 7'(j) - 7'sd2;
        idx = 8'(r) * 8'd10 + 8'(c);
        if (m[i*4+j]) begin
          if (r < 7'sd0 || r > 7'sd19 || c < 7'sd0 || c > 7'sd9) ok = 1'b0;
          else if (board[idx])                                   ok = 1'b0;
        end
      end
    return ok;
  endfunction

`ifdef PIECE_CTRL_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge refreshClock or negedge reset) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign spawn_type = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
`else
  logic [2:0] seq_type;
  always_ff @(posedge refreshClock or negedge reset) begin
    if (!reset)              seq_type <= 3'd0;
    else if (state == SPAWN) seq_type <= (seq_type == 3'd6) ? 3'd0 : seq_type + 3'd1;
  end
  assign spawn_type = seq_type;
`endif

  assign cur_mask   = piece_mask(btype, rot);
  assign rot_mask   = piece_mask(btype, rot + 2'd1);
  assign spawn_mask = base_mask(spawn_type);
  assign fits_rot   = fits(rot_mask, row, col, boardIn);
  assign fits_left  = fits(cur_mask, row, col - 4'd1, boardIn);
  assign fits_right = fits(cur_mask, row, col + 4'd1, boardIn);
  assign fits_down  = fits(cur_mask, row - 5'd1, col, boardIn);
  assign fits_spawn = fits(spawn_mask, 5'(SPAWN_ROW), 4'(SPAWN_COL), boardIn);

  always_ff @(posedge refreshClock or negedge reset) begin
    if (!reset) begin
      state     <= SETTLE;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      rot       <= '0;
      btype     <= '0;
      tick_pend <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      row       <= row_n;
      col       <= col_n;
      rot       <= rot_n;
      btype     <= btype_n;
      tick_pend <= tick_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    row_n       = row;
    col_n       = col;
    rot_n       = rot;
    btype_n     = btype;
    tick_pend_n = tick_pend | tick;
    setSignal   = 1'b0;
    setSpace    = '0;
    setRow      = '0;
    setCol      = '0;
    pieceSpace  = '0;
    gameOver    = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt == CW'(1)) begin
          state_n = SPAWN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SPAWN: begin
        btype_n     = spawn_type;
        rot_n       = 2'd0;
        row_n       = 5'(SPAWN_ROW);
        col_n       = 4'(SPAWN_COL);
        tick_pend_n = 1'b0;
        state_n     = fits_spawn ? ACTIVE : OVER;
      end
      ACTIVE: begin
        pieceSpace = cur_mask;
        if (btnDrop) begin
          state_n = DROP;
        end else if (btnRotate) begin
          if (fits_rot) rot_n = rot + 2'd1;
        end else if (btnLeft) begin
          if (fits_left) col_n = col - 4'd1;
        end else if (btnRight) begin
          if (fits_right) col_n = col + 4'd1;
        end else if (tick_pend) begin
          tick_pend_n = tick;
          if (fits_down) begin
            row_n = row - 5'd1;
          end else begin
            state_n = LOCK;
            cnt_n   = '0;
          end
        end
      end
      DROP: begin
        pieceSpace = cur_mask;
        if (fits_down) begin
          row_n = row - 5'd1;
        end else begin
          state_n = LOCK;
          cnt_n   = '0;
        end
      end
      LOCK: begin
        // Stamp data brackets the strobe by one cycle on each side.
        setSpace  = cur_mask;
        setRow    = row;
        setCol    = col;
        setSignal = (cnt != '0) && (cnt <= CW'(LOCK_HOLD));
        if (cnt == CW'(LOCK_HOLD + 1)) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      OVER: begin
        gameOver = 1'b1;
      end
      default: state_n = SETTLE;
    endcase
  end

  assign pieceRow  = row;
  assign pieceCol  = col;
  assign blockType = btype;

endmodule

// File: tb/tb_piece_controller.sv
// tb/tb_piece_controller.sv - directed table-driven bench for piece_controller.
module tb_piece_controller;

  logic         refreshClock, reset, tick, btnLeft, btnRight, btnRotate, btnDrop;
  logic [199:0] boardIn;
  logic         setSignal, gameOver;
  logic [15:0]  setSpace, pieceSpace;
  logic [4:0]   setRow, pieceRow;
  logic [3:0]   setCol, pieceCol;
  logic [2:0]   blockType;
  int           checks, errors;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_TK   = 5'b00001;
  localparam logic [4:0] B_R    = 5'b00010;
  localparam logic [4:0] B_L    = 5'b00100;
  localparam logic [4:0] B_ROT  = 5'b01000;
  localparam logic [4:0] B_DRP  = 5'b10000;

  typedef struct {
    logic [4:0]  btn;
    logic [15:0] space;
    logic [4:0]  row;
    logic [3:0]  col;
  } vec_t;

  piece_controller dut (
    .refreshClock(refreshClock), .reset(reset), .tick(tick),
    .btnLeft(btnLeft), .btnRight(btnRight), .btnRotate(btnRotate), .btnDrop(btnDrop),
    .boardIn(boardIn), .setSignal(setSignal), .setSpace(setSpace), .setRow(setRow),
    .setCol(setCol), .pieceSpace(pieceSpace), .pieceRow(pieceRow), .pieceCol(pieceCol),
    .blockType(blockType), .gameOver(gameOver)
  );

  initial begin
    refreshClock = 1'b0;
    forever #5 refreshClock = ~refreshClock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [4:0] b);
    {btnDrop, btnRotate, btnLeft, btnRight, tick} = b;
    @(posedge refreshClock);
    #1;
    {btnDrop, btnRotate, btnLeft, btnRight, tick} = B_NONE;
  endtask

  task automatic drop_to_next(input logic [15:0] lmask, input logic [4:0] lrow, input logic [3:0] lcol,
                              input logic [2:0] ntype, input logic [15:0] nmask);
    bit seen;
    cyc(B_DRP);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      cyc(B_NONE);
      if (setSpace != 16'h0) seen = 1'b1;
    end
    chk("lock_reached", 32'(seen), 32'd1);
    chk("lock_space", 32'(setSpace), 32'(lmask));
    chk("lock_row", 32'(setRow), 32'(lrow));
    chk("lock_col", 32'(setCol), 32'(lcol));
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cyc(B_NONE);
      if (pieceSpace != 16'h0) seen = 1'b1;
    end
    chk("spawn_reached", 32'(seen), 32'd1);
    chk("spawn_type", 32'(blockType), 32'(ntype));
    chk("spawn_mask", 32'(pieceSpace), 32'(nmask));
    chk("spawn_row", 32'(pieceRow), 32'd17);
    chk("spawn_col", 32'(pieceCol), 32'd4);
  endtask

  initial begin
    vec_t tab[23];
    bit   seen;

    tab[0]  = '{B_L,         16'h0F00, 5'd17, 4'd3};
    tab[1]  = '{B_L,         16'h0F00, 5'd17, 4'd2};
    tab[2]  = '{B_L,         16'h0F00, 5'd17, 4'd2};
    tab[3]  = '{B_L,         16'h0F00, 5'd17, 4'd2};
    tab[4]  = '{B_L,         16'h0F00, 5'd17, 4'd2};
    tab[5]  = '{B_R,         16'h0F00, 5'd17, 4'd3};
    tab[6]  = '{B_R,         16'h0F00, 5'd17, 4'd4};
    tab[7]  = '{B_ROT | B_L, 16'h4444, 5'd17, 4'd4};
    tab[8]  = '{B_L,         16'h4444, 5'd17, 4'd3};
    tab[9]  = '{B_L,         16'h4444, 5'd17, 4'd2};
    tab[10] = '{B_L,         16'h4444, 5'd17, 4'd1};
    tab[11] = '{B_L,         16'h4444, 5'd17, 4'd0};
    tab[12] = '{B_L,         16'h4444, 5'd17, 4'd0};
    tab[13] = '{B_ROT,       16'h4444, 5'd17, 4'd0};
    tab[14] = '{B_R,         16'h4444, 5'd17, 4'd1};
    tab[15] = '{B_R,         16'h4444, 5'd17, 4'd2};
    tab[16] = '{B_ROT,       16'h00F0, 5'd17, 4'd2};
    tab[17] = '{B_ROT,       16'h2222, 5'd17, 4'd2};
    tab[18] = '{B_ROT,       16'h0F00, 5'd17, 4'd2};
    tab[19] = '{B_TK,        16'h0F00, 5'd17, 4'd2};
    tab[20] = '{B_NONE,      16'h0F00, 5'd16, 4'd2};
    tab[21] = '{B_R | B_TK,  16'h0F00, 5'd16, 4'd3};
    tab[22] = '{B_NONE,      16'h0F00, 5'd15, 4'd3};

    checks = 0;
    errors = 0;
    reset = 1'b0;
    boardIn = '0;
    {btnDrop, btnRotate, btnLeft, btnRight, tick} = B_NONE;
    repeat (2) @(posedge refreshClock);
    #1;
    chk("rst_setSignal", 32'(setSignal), 32'd0);
    chk("rst_setSpace", 32'(setSpace), 32'd0);
    chk("rst_setRow", 32'(setRow), 32'd0);
    chk("rst_setCol", 32'(setCol), 32'd0);
    chk("rst_pieceSpace", 32'(pieceSpace), 32'd0);
    chk("rst_pieceRow", 32'(pieceRow), 32'd0);
    chk("rst_pieceCol", 32'(pieceCol), 32'd0);
    chk("rst_blockType", 32'(blockType), 32'd0);
    chk("rst_gameOver", 32'(gameOver), 32'd0);

    reset = 1'b1;
    cyc(B_NONE);
    cyc(B_NONE);
    chk("settle_space", 32'(pieceSpace), 32'd0);
    cyc(B_NONE);
    chk("first_space", 32'(pieceSpace), 32'h0660);
    chk("first_row", 32'(pieceRow), 32'd17);
    chk("first_col", 32'(pieceCol), 32'd4);
    chk("first_type", 32'(blockType), 32'd0);

    // Gravity on the O piece: 16 steps, then the 17th tick locks it.
    for (int k = 0; k < 16; k++) begin
      cyc(B_TK);
      cyc(B_NONE);
      chk("gravity_row", 32'(pieceRow), 32'(16 - k));
    end
    cyc(B_TK);
    cyc(B_NONE);
    chk("lock0_piece", 32'(pieceSpace), 32'd0);
    chk("lock0_sig", 32'(setSignal), 32'd0);
    chk("lock0_space", 32'(setSpace), 32'h0660);
    chk("lock0_row", 32'(setRow), 32'd1);
    chk("lock0_col", 32'(setCol), 32'd4);
    for (int t = 1; t <= 9; t++) begin
      cyc((t == 1) ? B_TK : B_NONE);
      chk($sformatf("lock_sig_t%0d", t), 32'(setSignal), (t <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("lock_space_t%0d", t), 32'(setSpace), (t <= 5) ? 32'h0660 : 32'h0);
      chk($sformatf("respawn_t%0d", t), 32'(pieceSpace), (t == 9) ? 32'h0F00 : 32'h0);
    end
    chk("second_type", 32'(blockType), 32'd1);
    cyc(B_NONE);
    chk("spawn_no_fall", 32'(pieceRow), 32'd17);

    for (int i = 0; i < 23; i++) begin
      cyc(tab[i].btn);
      chk($sformatf("vec%0d_space", i), 32'(pieceSpace), 32'(tab[i].space));
      chk($sformatf("vec%0d_row", i), 32'(pieceRow), 32'(tab[i].row));
      chk($sformatf("vec%0d_col", i), 32'(pieceCol), 32'(tab[i].col));
    end

    drop_to_next(16'h0F00, 5'd0, 4'd3, 3'd2, 16'h0630);
    drop_to_next(16'h0630, 5'd1, 4'd4, 3'd3, 16'h0360);
    drop_to_next(16'h0360, 5'd1, 4'd4, 3'd4, 16'h0710);
    drop_to_next(16'h0710, 5'd1, 4'd4, 3'd5, 16'h0740);
    drop_to_next(16'h0740, 5'd1, 4'd4, 3'd6, 16'h0720);

    // Hard drop of the T piece with a tick mid-fall.
    cyc(B_DRP);
    chk("drop_start_row", 32'(pieceRow), 32'd17);
    chk("drop_start_space", 32'(pieceSpace), 32'h0720);
    for (int k = 1; k <= 16; k++) begin
      cyc((k == 5) ? B_TK : B_NONE);
      chk($sformatf("drop_row_%0d", k), 32'(pieceRow), 32'(17 - k));
    end
    cyc(B_NONE);
    chk("drop_lock_piece", 32'(pieceSpace), 32'd0);
    chk("drop_lock_space", 32'(setSpace), 32'h0720);
    chk("drop_lock_row", 32'(setRow), 32'd1);
    chk("drop_lock_col", 32'(setCol), 32'd4);

    // Spawn blocked by full rows 16-17.
    reset = 1'b0;
    boardIn = '0;
    for (int i = 160; i < 180; i++) boardIn[i] = 1'b1;
    @(posedge refreshClock);
    #1;
    reset = 1'b1;
    cyc(B_NONE);
    cyc(B_NONE);
    cyc(B_NONE);
    chk("over_flag", 32'(gameOver), 32'd1);
    chk("over_piece", 32'(pieceSpace), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(B_DRP | B_TK | B_L);
      chk("over_hold", 32'(gameOver), 32'd1);
      chk("over_no_set", 32'(setSignal), 32'd0);
    end
    #2 reset = 1'b0;
    #1 chk("over_async_clear", 32'(gameOver), 32'd0);

    // Reset arriving while the stamp strobe is high.
    boardIn = '0;
    @(posedge refreshClock);
    #1;
    reset = 1'b1;
    cyc(B_NONE);
    cyc(B_NONE);
    cyc(B_NONE);
    chk("rerun_space", 32'(pieceSpace), 32'h0660);
    chk("rerun_type", 32'(blockType), 32'd0);
    cyc(B_DRP);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      cyc(B_NONE);
      if (setSignal) seen = 1'b1;
    end
    chk("midlock_reached", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midlock_sig", 32'(setSignal), 32'd0);
    chk("midlock_space", 32'(setSpace), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
